counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Run controller for an up/down counter datapath (one step per rising edge of
//  its enable input, direction from up_down, reloaded to its init value on reset).
//  Turns start/stop buttons plus a mode select into rate-limited step pulses and
//  a direction. Watches count feedback against low/high limits; runs to a limit
//  or bounces between limits.
// PARAMETERS
//  WIDTH     8  counter width; width of count, low_limit, high_limit
//  PRESCALE  4  clk cycles per step tick; legal range >= 2
// PORTS
//  clk         in   1      clock; all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  start_btn   in   1      start/resume; rising edge acts
//  stop_btn    in   1      pause/abort; rising edge acts
//  mode        in   2      00 up, 01 down, 10 ping-pong, 11 hold; latched at start
//  low_limit   in   WIDTH  lower bound, unsigned
//  high_limit  in   WIDTH  upper bound, unsigned
//  count       in   WIDTH  counter output (feedback)
//  step        out  1      to counter enable; 1-cycle high pulse per step
//  up_down     out  1      to counter direction; 1 = up
//  cnt_reset   out  1      to counter reset; 1-cycle pulse reloads init value
//  busy        out  1      high in RUN or PAUSE
//  done        out  1      1-cycle pulse when a run reaches its limit
//  state       out  2      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
// BEHAVIOUR
//  - Reset: IDLE; step, up_down, cnt_reset, busy, done = 0; prescaler = 0;
//    start/stop edge regs = 0; latched mode = 00.
//  - Edge detect: registered previous button level. Edge = btn & ~prev.
//    Held button = one event.
//  - Same-cycle start and stop edges: stop wins; start is dropped.
//  - IDLE + start: latch mode, cnt_reset=1 for that next cycle, clear prescaler,
//    go RUN. up_down = 1 for up/ping-pong, 0 for down.
//    Mode 11 (hold): go RUN, never step.
//  - RUN: prescaler counts 0..PRESCALE-1. Tick when it wraps; first tick
//    PRESCALE cycles after entry. On each tick, compare count:
//      up:    count==high_limit -> DONE, else step, up_down=1
//      down:  count==low_limit  -> DONE, else step, up_down=0
//      ping:  at high_limit set dir=0, at low_limit set dir=1 (dir change
//             takes effect that same tick); then step with dir.
//             low_limit==high_limit -> DONE
//  - A step registered high at edge k changes count at edge k+1. PRESCALE>=2
//    keeps step low between pulses and makes each compare see the updated count.
//  - Count outside [low,high]: up/down keep stepping until equality
//    (wrap-around is the counter's own modulo 2^WIDTH).
//    Ping-pong uses >=high / <=low for the direction change.
//  - RUN + stop -> PAUSE. Prescaler frozen; no steps; up_down and dir held.
//  - PAUSE + start -> RUN; prescaler resumes. PAUSE + stop -> IDLE; no done pulse.
//  - DONE: done=1 for exactly one cycle, then IDLE. Buttons ignored in DONE.
//  - Limits are sampled live at each tick; mode is not (latched).
//  - Reset mid-run: immediate IDLE and all outputs 0; an in-flight step is cut.
// CONFIGURATION
//  SEQ_AUTO_RELOAD_EN
//  - Defined: up/down modes do not stop at the limit.
//    Limit hit -> done pulse + cnt_reset pulse in the same cycle; stay in RUN;
//    prescaler restarts at 0.
//    Ping-pong and hold unchanged; stop is the only way out of RUN.
//  - Undefined: behaviour as in BEHAVIOUR (limit -> DONE -> IDLE).
// TESTING
//  1 Counter init 0, PRESCALE=4, up, low=0 high=5, start -> cnt_reset pulse;
//    5 steps 4 cycles apart; count 5; done once; state back to 00.
//  2 Init 9, down, low=3 -> 6 steps with up_down=0; done when count==3;
//    no step after it.
//  3 Init 2, ping-pong, low=2 high=4 -> count 2,3,4,3,2,3...;
//    up_down flips at 4 and at 2; stop then stop -> IDLE, no done pulse.
//  4 Up run, stop at count 3 -> 10 idle cycles, no step, count stays 3;
//    start -> resumes, reaches high=5.
//  5 Start and stop same cycle in IDLE -> stays IDLE. Held start_btn for
//    20 cycles -> single run. Reset asserted mid-step -> all outputs 0 at once.
//  6 SEQ_AUTO_RELOAD_EN, up, init 0, high=2 -> done + cnt_reset every 3rd tick;
//    busy stays 1 until stop.

Source files
------------

// File: rtl/counter_sequencer.sv
// Run controller for an external up/down counter: button edges and mode become prescaled step pulses, one step per tick.
// All outputs are registered (a tick shows one cycle later); define SEQ_AUTO_RELOAD_EN to make up/down runs reload at the limit.
module counter_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] low_limit,
    input  logic [WIDTH-1:0] high_limit,
    input  logic [WIDTH-1:0] count,
    output logic             step,
    output logic             up_down,
    output logic             cnt_reset,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    localparam int            PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          start_prev_q, stop_prev_q;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic          up_down_q, up_down_d;
    logic          cnt_reset_q, cnt_reset_d;
    logic          done_q, done_d;

    logic start_edge, stop_edge, start_ev, tick;
    logic limit_hit, finish_run, ping_dir;

    always_comb begin
        start_edge = start_btn & ~start_prev_q;
        stop_edge  = stop_btn & ~stop_prev_q;
        start_ev   = start_edge & ~stop_edge;
        tick       = (state_q == RUN) && !stop_edge && (presc_q == PRESC_LAST);

        limit_hit = 1'b0;
        case (mode_q)
            MODE_UP:   limit_hit = (count == high_limit);
            MODE_DOWN: limit_hit = (count == low_limit);
            MODE_PING: limit_hit = (low_limit == high_limit);
            default:   limit_hit = 1'b0;
        endcase

        // Inequalities let a count outside the window still turn around.
        ping_dir = dir_q;
        if (count >= high_limit)
            ping_dir = 1'b0;
        else if (count <= low_limit)
            ping_dir = 1'b1;

`ifdef SEQ_AUTO_RELOAD_EN
        finish_run = limit_hit && (mode_q == MODE_PING);
`else
        finish_run = limit_hit;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ev) state_d = RUN;
            RUN: begin
                if (stop_edge)
                    state_d = PAUSE;
                else if (tick && finish_run)
                    state_d = DONE;
            end
            PAUSE: begin
                if (stop_edge)
                    state_d = IDLE;
                else if (start_ev)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        presc_d     = presc_q;
        dir_d       = dir_q;
        up_down_d   = up_down_q;
        step_d      = 1'b0;
        cnt_reset_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev) begin
                    mode_d      = mode;
                    presc_d     = '0;
                    cnt_reset_d = 1'b1;
                    dir_d       = (mode == MODE_UP) || (mode == MODE_PING);
                    up_down_d   = dir_d;
                end
            end
            RUN: begin
                if (!stop_edge) begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (limit_hit) begin
                            done_d      = 1'b1;
                            // Only an auto-reloading run keeps going from the init value.
                            cnt_reset_d = !finish_run;
                        end else if (mode_q != MODE_HOLD) begin
                            step_d = 1'b1;
                            if (mode_q == MODE_PING) begin
                                dir_d     = ping_dir;
                                up_down_d = ping_dir;
                            end else begin
                                up_down_d = (mode_q == MODE_UP);
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            mode_q       <= MODE_UP;
            presc_q      <= '0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            up_down_q    <= 1'b0;
            cnt_reset_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            stop_prev_q  <= stop_btn;
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            up_down_q    <= up_down_d;
            cnt_reset_q  <= cnt_reset_d;
            done_q       <= done_d;
        end
    end

    assign step      = step_q;
    assign up_down   = up_down_q;
    assign cnt_reset = cnt_reset_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign state     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the loop; expected pulses are queued and checked by a monitor.
module tb_counter_sequencer;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start_btn;
    logic         stop_btn;
    logic [1:0]   mode;
    logic [W-1:0] low_limit;
    logic [W-1:0] high_limit;
    logic [W-1:0] count = '0;
    logic         step;
    logic         up_down;
    logic         cnt_reset;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    logic [W-1:0] init_val;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    int           c0;
    int           c1;

    typedef struct packed {
        int           cyc;
        logic         step;
        logic         done;
        logic         crst;
        logic         ud;
        logic [W-1:0] cnt;
        logic         chk_cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    counter_sequencer #(.WIDTH(W), .PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .mode       (mode),
        .low_limit  (low_limit),
        .high_limit (high_limit),
        .count      (count),
        .step       (step),
        .up_down    (up_down),
        .cnt_reset  (cnt_reset),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The counter being sequenced: reload on cnt_reset, otherwise one step per step pulse.
    always @(posedge clk) begin
        if (cnt_reset)
            count <= init_val;
        else if (step)
            count <= up_down ? count + 1'b1 : count - 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && (step || done || cnt_reset)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d step=%0b done=%0b cnt_reset=%0b up_down=%0b count=%0d",
                         cyc, step, done, cnt_reset, up_down, count);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.step != step || mon_e.done != done || mon_e.crst != cnt_reset ||
                    mon_e.ud != up_down || (mon_e.chk_cnt && mon_e.cnt != count)) begin
                    n_err++;
                    $display("FAIL event got cyc=%0d step=%0b done=%0b crst=%0b ud=%0b cnt=%0d expected cyc=%0d step=%0b done=%0b crst=%0b ud=%0b cnt=%0d",
                             cyc, step, done, cnt_reset, up_down, count,
                             mon_e.cyc, mon_e.step, mon_e.done, mon_e.crst, mon_e.ud, mon_e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic s, input logic d, input logic r, input logic u,
                        input logic [W-1:0] v, input logic k);
        ev_t e;
        e.cyc = c; e.step = s; e.done = d; e.crst = r; e.ud = u; e.cnt = v; e.chk_cnt = k;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
    endtask

    task automatic setup(input logic [1:0] m, input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic [W-1:0] iv);
        mode = m; low_limit = lo; high_limit = hi; init_val = iv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0;
        setup(2'b00, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_step", int'(step), 0);
        check("rst_up_down", int'(up_down), 0);
        check("rst_cnt_reset", int'(cnt_reset), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Up run 0 -> 5
        setup(2'b00, 8'd0, 8'd5, 8'd0);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        for (int k = 1; k <= 5; k++) push(c0 + 1 + 4 * k, 1'b1, 1'b0, 1'b0, 1'b1, W'(k - 1), 1'b1);
        push(c0 + 25, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b1);
        press_start();
        wait_to(c0 + 3);
        check("t1_state_run", int'(state), 1);
        check("t1_busy_run", int'(busy), 1);
        wait_to(c0 + 27);
        check("t1_state_end", int'(state), 0);
        check("t1_busy_end", int'(busy), 0);
        check("t1_count", int'(count), 5);

        // Down run 9 -> 3
        setup(2'b01, 8'd3, 8'd200, 8'd9);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 6; k++) push(c0 + 1 + 4 * k, 1'b1, 1'b0, 1'b0, 1'b0, W'(10 - k), 1'b1);
        push(c0 + 29, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1);
        press_start();
        wait_to(c0 + 36);
        check("t2_state_end", int'(state), 0);
        check("t2_count", int'(count), 3);

        // Ping-pong 2..4, then stop, stop
        setup(2'b10, 8'd2, 8'd4, 8'd2);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        push(c0 + 5,  1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1);
        push(c0 + 9,  1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
        push(c0 + 13, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1);
        push(c0 + 17, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
        push(c0 + 21, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1);
        push(c0 + 25, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
        press_start();
        wait_to(c0 + 26);
        press_stop();
        check("t3_state_pause", int'(state), 2);
        check("t3_dir_held", int'(up_down), 1);
        wait_to(c0 + 29);
        press_stop();
        wait_to(c0 + 36);
        check("t3_state_idle", int'(state), 0);
        check("t3_busy_idle", int'(busy), 0);
        check("t3_count", int'(count), 4);

        // Up run paused at 3, resumed to 5
        setup(2'b00, 8'd0, 8'd5, 8'd0);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        for (int k = 1; k <= 3; k++) push(c0 + 1 + 4 * k, 1'b1, 1'b0, 1'b0, 1'b1, W'(k - 1), 1'b1);
        press_start();
        wait_to(c0 + 14);
        press_stop();
        repeat (10) @(negedge clk);
        check("t4_state_pause", int'(state), 2);
        check("t4_busy_pause", int'(busy), 1);
        check("t4_count_pause", int'(count), 3);
        c1 = cyc;
        push(c1 + 4,  1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
        push(c1 + 8,  1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1);
        push(c1 + 12, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b1);
        press_start();
        wait_to(c1 + 14);
        check("t4_state_end", int'(state), 0);
        check("t4_count_end", int'(count), 5);

        // Simultaneous start and stop in IDLE
        start_btn = 1'b1; stop_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0; stop_btn = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_both_state", int'(state), 0);
        check("t5_both_busy", int'(busy), 0);

        // Held start button gives a single run
        setup(2'b00, 8'd0, 8'd2, 8'd0);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        push(c0 + 5,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
        push(c0 + 9,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        push(c0 + 13, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1);
        start_btn = 1'b1;
        wait_to(c0 + 16);
        check("t5_held_state", int'(state), 0);
        wait_to(c0 + 20);
        start_btn = 1'b0;
        wait_to(c0 + 24);
        check("t5_held_end", int'(state), 0);
        check("t5_held_count", int'(count), 2);

        // Reset while a step pulse is high
        setup(2'b00, 8'd0, 8'd5, 8'd0);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        push(c0 + 5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
        press_start();
        wait_to(c0 + 5);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_step", int'(step), 0);
        check("t5_rst_state", int'(state), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_up_down", int'(up_down), 0);
        check("t5_rst_cnt_reset", int'(cnt_reset), 0);
        check("t5_rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_rst_count", int'(count), 0);
        check("t5_rst_idle", int'(state), 0);

`ifdef SEQ_AUTO_RELOAD_EN
        // Auto reload: done and cnt_reset together every third tick
        setup(2'b00, 8'd0, 8'd2, 8'd0);
        c0 = cyc;
        push(c0 + 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        push(c0 + 5,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
        push(c0 + 9,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        push(c0 + 13, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
        push(c0 + 17, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
        push(c0 + 21, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        push(c0 + 25, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
        press_start();
        wait_to(c0 + 14);
        check("t6_busy_after_hit", int'(busy), 1);
        check("t6_state_after_hit", int'(state), 1);
        wait_to(c0 + 26);
        press_stop();
        check("t6_state_pause", int'(state), 2);
        check("t6_busy_pause", int'(busy), 1);
        press_stop();
        repeat (2) @(negedge clk);
        check("t6_state_idle", int'(state), 0);
        check("t6_count", int'(count), 0);
`endif

        repeat (4) @(negedge clk);
        check("leftover_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
